// File: rtl/wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module   : wb_bram_burst
// Brief    : Wishbone B4 block-RAM slave with byte lanes, zero-wait writes and
//            registered-feedback incrementing read bursts (linear, wrap4/8/16).
//            Optional out-of-range detection: define WB_BRAM_ERR_EN to answer
//            requests with address bits above the memory window by wb_err.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bram_burst #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADR_WIDTH = 11,
    parameter int ADR_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADR_WIDTH-1:0]    wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_ms,
    input  logic [2:0]              wb_cti,
    input  logic [1:0]              wb_bte,
    output logic [DATA_WIDTH-1:0]   wb_dat_sm,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_rty
);

    localparam int c_SEL_W  = DATA_WIDTH / 8;
    localparam int c_BL     = $clog2(c_SEL_W);
    localparam int c_DEPTH  = 2 ** MEM_ADR_WIDTH;
    localparam int c_HI_LSB = MEM_ADR_WIDTH + c_BL;

    localparam logic [2:0] c_CTI_INCR = 3'b010;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FIRST = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;

    localparam logic [MEM_ADR_WIDTH-1:0] c_ONES = {MEM_ADR_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0]    r_mem [0:c_DEPTH-1];
    logic [1:0]               r_state;
    logic [MEM_ADR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0]    r_dat;
    logic                     r_ack;
    logic                     r_err;

    logic                     w_req;
    logic [MEM_ADR_WIDTH-1:0] w_idx;
    logic                     w_adr_err;
    logic                     w_wr_ack;
    logic                     w_wr_err;
    logic                     w_burst_ack;
    logic [MEM_ADR_WIDTH-1:0] w_wrap_mask;
    logic [MEM_ADR_WIDTH-1:0] w_ptr_inc;
    logic [MEM_ADR_WIDTH-1:0] w_next_ptr;
    logic                     w_unused_adr;

    assign w_req = wb_cyc & wb_stb;
    assign w_idx = wb_adr[c_HI_LSB-1:c_BL];

`ifdef WB_BRAM_ERR_EN
    // Any set address bit above the memory window marks the access as out of range.
    if (ADR_WIDTH > c_HI_LSB) begin : g_adr_hi
        assign w_adr_err = |wb_adr[ADR_WIDTH-1:c_HI_LSB];
    end else begin : g_adr_no_hi
        assign w_adr_err = 1'b0;
    end
`else
    // Upper address bits are don't-care: the memory aliases across them.
    assign w_adr_err = 1'b0;
`endif

    // Byte-offset bits (and upper bits when aliasing) carry no information here.
    assign w_unused_adr = &{1'b0, wb_adr};

    // Writes complete in the request cycle, independent of the read FSM.
    assign w_wr_ack = w_req & wb_we & ~w_adr_err;
    assign w_wr_err = w_req & wb_we & w_adr_err;

    // In a burst every beat the master presents is acknowledged at once.
    assign w_burst_ack = (r_state == c_BURST) & w_req & ~wb_we;

    // Burst pointer successor: only the bits inside the wrap window count up.
    always_comb begin
        w_wrap_mask = c_ONES;
        case (wb_bte)
            2'b01:   w_wrap_mask = MEM_ADR_WIDTH'(3);
            2'b10:   w_wrap_mask = MEM_ADR_WIDTH'(7);
            2'b11:   w_wrap_mask = MEM_ADR_WIDTH'(15);
            default: w_wrap_mask = c_ONES;
        endcase
        w_ptr_inc  = r_ptr + MEM_ADR_WIDTH'(1);
        w_next_ptr = (r_ptr & ~w_wrap_mask) | (w_ptr_inc & w_wrap_mask);
    end

    // Byte-lane write port; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ack) begin
            for (int i = 0; i < c_SEL_W; i++) begin
                if (wb_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wb_dat_ms[8*i +: 8];
                end
            end
        end
    end

    // Read FSM: one wait state on the first beat, then a prefetch each beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (!wb_cyc) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_req && !wb_we) begin
                            r_ptr   <= w_idx;
                            r_dat   <= r_mem[w_idx];
                            r_ack   <= ~w_adr_err;
                            r_err   <= w_adr_err;
                            r_state <= c_FIRST;
                        end
                    end
                    c_FIRST: begin
                        // An error beat always ends the burst.
                        if (r_ack && (wb_cti == c_CTI_INCR)) begin
                            r_ptr   <= w_next_ptr;
                            r_dat   <= r_mem[w_next_ptr];
                            r_state <= c_BURST;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_BURST: begin
                        if (w_req && !wb_we) begin
                            if (wb_cti == c_CTI_INCR) begin
                                r_ptr <= w_next_ptr;
                                r_dat <= r_mem[w_next_ptr];
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign wb_dat_sm = r_dat;
    assign wb_ack    = w_wr_ack | r_ack | w_burst_ack;
`ifdef WB_BRAM_ERR_EN
    assign wb_err    = w_wr_err | r_err;
`else
    assign wb_err    = 1'b0;
`endif
    assign wb_rty    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bram_burst
// Brief    : Self-checking bench for wb_bram_burst (default parameters) using
//            directed scenarios plus randomized traffic against a word-array
//            reference model. Honours WB_BRAM_ERR_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bram_burst;

    localparam int c_WORDS = 2048;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_ms;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;

    logic [31:0] model_mem [0:c_WORDS-1];
    int          n_checks;
    int          n_errors;

    wb_bram_burst #(
        .DATA_WIDTH   (32),
        .MEM_ADR_WIDTH(11),
        .ADR_WIDTH    (32)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_dat_ms(wb_dat_ms),
        .wb_cti   (wb_cti),
        .wb_bte   (wb_bte),
        .wb_dat_sm(wb_dat_sm),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .wb_rty   (wb_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address outside the 2048-word window is only an error with the feature on.
    function automatic bit adr_is_err(input logic [31:0] adr);
`ifdef WB_BRAM_ERR_EN
        return (adr >> 13) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] adr);
        return int'((adr >> 2) & 32'h7FF);
    endfunction

    // i-th word of a burst: linear counts modulo memory size, wrap-N stays
    // inside the aligned N-word block that holds the start word.
    function automatic int burst_word(input int start, input int bte, input int i);
        int n;
        if (bte == 0) return (start + i) % c_WORDS;
        n = 1 << (bte + 1);
        return (start / n) * n + ((start % n) + i) % n;
    endfunction

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
        wb_sel = '0; wb_dat_ms = '0; wb_cti = 3'b000; wb_bte = 2'b00;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit e;
        int w;
        e = adr_is_err(adr);
        w = word_of(adr);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr;
        wb_dat_ms = dat; wb_sel = sel; wb_cti = 3'b000;
        @(negedge clk);
        check("wr_ack", wb_ack, !e);
        check("wr_err", wb_err, e);
        if (!e) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[w][8*b +: 8] = dat[8*b +: 8];
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] adr);
        bit e;
        int w;
        e = adr_is_err(adr);
        w = word_of(adr);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_cti = 3'b000;
        @(negedge clk);
        check("rd_wait_ack", wb_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        if (e) begin
            check("rd_err", wb_err, 1);
            check("rd_err_noack", wb_ack, 0);
        end else begin
            check("rd_ack", wb_ack, 1);
            check("rd_dat", wb_dat_sm, model_mem[w]);
        end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("rd_pulse_ack", wb_ack, 0);
        check("rd_pulse_err", wb_err, 0);
        @(posedge clk); #1;
    endtask

    // gap_at = k inserts one stb-low cycle after beat k (1-based); 0 = none.
    task automatic burst_rd(input int start, input int bte, input int len, input int gap_at);
        int w;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_bte = 2'(bte);
        wb_adr = 32'(start) << 2;
        wb_cti = (len > 1) ? 3'b010 : 3'b111;
        @(negedge clk);
        check("brst_wait_ack", wb_ack, 0);
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            w = burst_word(start, bte, i);
            wb_stb = 1'b1;
            wb_adr = 32'(w) << 2;
            wb_cti = (i == len - 1) ? 3'b111 : 3'b010;
            @(negedge clk);
            check("brst_ack", wb_ack, 1);
            check("brst_dat", wb_dat_sm, model_mem[w]);
            @(posedge clk); #1;
            if (gap_at == i + 1 && i < len - 1) begin
                wb_stb = 1'b0;
                @(negedge clk);
                check("brst_gap_ack", wb_ack, 0);
                check("brst_gap_dat", wb_dat_sm, model_mem[burst_word(start, bte, i + 1)]);
                @(posedge clk); #1;
            end
        end
        bus_idle();
        @(negedge clk);
        check("brst_end_ack", wb_ack, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int op, w, bte, len;
        logic [31:0] adr;
        n_checks = 0;
        n_errors = 0;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", wb_ack, 0);
        check("rst_err", wb_err, 0);
        check("rst_dat", wb_dat_sm, 0);
        check("rst_rty", wb_rty, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Every word holds its own index.
        for (int i = 0; i < c_WORDS; i++) wr(32'(i) << 2, 32'(i), 4'hF);

        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10);

        wr(32'h80, 32'hAABBCCDD, 4'hF);
        wr(32'h80, 32'h11223344, 4'b0101);
        rd(32'h80);

        burst_rd(11'h7FE, 0, 4, 0);
        burst_rd(5, 1, 4, 2);

        // Drop wb_cyc in the middle of a burst, then a classic read.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_bte = 2'b00;
        wb_adr = 32'd10 << 2; wb_cti = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_beat0", wb_dat_sm, model_mem[10]);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_beat1", wb_dat_sm, model_mem[11]);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("drop_ack", wb_ack, 0);
        @(posedge clk); #1;
        rd(32'd3 << 2);

        // Out-of-range write: err with the feature, alias onto word 0 without.
        wr(32'h0001_0000, 32'h5A5A5A5A, 4'hF);
        rd(32'h0);
        rd(32'h0001_0004);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 3);
            w  = $urandom_range(0, c_WORDS - 1);
            adr = 32'(w) << 2;
            if ($urandom_range(0, 7) == 0) adr = adr | (32'($urandom_range(1, 15)) << 13);
            case (op)
                0, 1: wr(adr, $urandom, 4'($urandom_range(0, 15)));
                2:    rd(adr);
                default: begin
                    bte = $urandom_range(0, 3);
                    len = $urandom_range(1, 8);
                    burst_rd(w, bte, len, $urandom_range(0, len));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
